// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Multi-cycle data-memory stage that sits behind the CPU load/store path.
// It owns a word-addressed DEPTH x 32 storage array and services one load or
// store at a time. A request is accepted on a valid/ready handshake, the block
// stays busy for LATENCY-1 cycles, and then raises a one-cycle response.
// The array is read or written on the edge that enters the response cycle.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       synchronous, active-high reset
//   req_valid   in   1       request present this cycle
//   req_ready   out  1       block can accept a request this cycle
//   req_write   in   1       1 = store, 0 = load (sampled on acceptance)
//   req_addr    in   ADDR_W  byte address (sampled on acceptance)
//   req_wdata   in   32      store data (sampled on acceptance)
//   resp_valid  out  1       one-cycle pulse: access complete
//   resp_rdata  out  32      load data, valid with resp_valid, then held
//   resp_err    out  1       misaligned or out-of-range access, then held
//   busy        out  1       stall request to the CPU while an access is in flight
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 16384,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Depth expressed at the width of the full word index so the range check
    // looks at every address bit (no modulo-DEPTH aliasing).
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic               commit_s;

    logic               wr_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [31:0]        wdata_r;

    logic               op_write_s;
    logic [ADDR_W-1:0]  op_addr_s;
    logic [31:0]        op_wdata_s;
    logic [IDX_W-1:0]   op_idx_s;
    logic               op_fault_s;

    logic               req_ready_r;
    logic               busy_r;
    logic               resp_valid_r;
    logic [31:0]        resp_rdata_r;
    logic               resp_err_r;

    logic [31:0]        mem_r [DEPTH];

    // A byte address faults when it is not word aligned or its word index
    // lies beyond the end of the array.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= DEPTH_IDX);
    endfunction

    // Operands of the committing access. With LATENCY==1 the commit happens on
    // the acceptance edge itself, so the live request is used in IDLE.
    always_comb begin
        op_write_s = wr_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            op_write_s = req_write;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_write_s = wr_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
        op_idx_s   = op_addr_s[IDX_W+1:2];
        op_fault_s = addr_fault(op_addr_s);
    end

    // Next-state, latency counter and commit strobe.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        commit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_nx_s = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_nx_s = ST_BUSY;
                    end else begin
                        state_nx_s = ST_RESP;
                        commit_s   = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = ST_RESP;
                    cnt_nx_s   = '0;
                    commit_s   = 1'b1;
                end else begin
                    state_nx_s = ST_BUSY;
                    cnt_nx_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State, counter and registered handshake/response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            req_ready_r  <= (state_nx_s == ST_IDLE);
            busy_r       <= (state_nx_s == ST_BUSY);
            resp_valid_r <= (state_nx_s == ST_RESP);
            if (commit_s) begin
                resp_err_r <= op_fault_s;
                if (op_fault_s || op_write_s) begin
                    resp_rdata_r <= 32'h0000_0000;
                end else begin
                    resp_rdata_r <= mem_r[op_idx_s];
                end
            end else begin
                resp_err_r   <= resp_err_r;
                resp_rdata_r <= resp_rdata_r;
            end
        end
    end

    // Request capture on acceptance; held for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            wr_r    <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else begin
            wr_r    <= wr_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Array write on the commit edge; a reset on that edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && commit_s && op_write_s && !op_fault_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign busy       = busy_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule
